hazard_pipe_tracker: RTL and testbench

HAZARD_PIPE_TRACKER -- requirements
Module: hazard_pipe_tracker

---
 rtl/hazard_pipe_tracker_pkg.sv | 49 ++++
 rtl/hazard_pipe_tracker_stage_reg.sv | 43 ++++
 rtl/hazard_pipe_tracker.sv | 202 ++++++++++++++++++++
 tb/tb_hazard_pipe_tracker.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pipe_tracker_pkg.sv
// Shared definitions for the hazard pipeline tracker.
// Holds the register-ID and counter widths, the per-stage field bundles
// and the bubble encoding (every field zero) used by all stage registers.
package hazard_pipe_tracker_pkg;

  localparam int REG_ID_W = 5;
  localparam int CNT_W    = 16;

  typedef logic [REG_ID_W-1:0] reg_id_t;
  typedef logic [CNT_W-1:0]    cnt_t;

  localparam cnt_t CNT_MAX = '1;

  // Fields carried from ID into EX. The hazard checker needs the source
  // register IDs and their want/need qualifiers while the instruction is in EX.
  typedef struct packed {
    logic    valid;
    reg_id_t rs;
    reg_id_t rt;
    reg_id_t rd;
    logic    reg_w;
    logic    mem_r;
    logic    wants_rs;
    logic    needs_rs;
    logic    wants_rt;
    logic    needs_rt;
  } ex_stage_t;

  // MEM and WB only need the destination side for forwarding decisions.
  typedef struct packed {
    logic    valid;
    reg_id_t rd;
    logic    reg_w;
    logic    mem_r;
  } mem_stage_t;

  localparam int EX_STAGE_W  = $bits(ex_stage_t);
  localparam int MEM_STAGE_W = $bits(mem_stage_t);

  // A bubble is an all-zero stage: not valid, no register IDs, no writes.
  localparam ex_stage_t  EX_BUBBLE  = '0;
  localparam mem_stage_t MEM_BUBBLE = '0;

  // Saturating increment for the event counters.
  function automatic cnt_t sat_inc(input cnt_t c);
    return (c == CNT_MAX) ? c : c + cnt_t'(1);
  endfunction

endpackage

// File: rtl/hazard_pipe_tracker_stage_reg.sv
// Generic pipeline stage register with hold / bubble / load controls.
// Ports: clk_i, rst_i (async active-high, resets to BUBBLE), hold_i, bubble_i,
//        load_i, d_i[W] -> q_o[W]. Priority: hold > bubble > load > keep.
module pipe_stage_reg #(
  parameter int           W      = 1,
  parameter logic [W-1:0] BUBBLE = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         hold_i,
  input  logic         bubble_i,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (hold_i) begin
      q_d = q_q;
    end else if (bubble_i) begin
      q_d = BUBBLE;
    end else if (load_i) begin
      q_d = d_i;
    end
  end

  // Reset is asynchronous so the stage reads as a bubble immediately,
  // without waiting for an edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= BUBBLE;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/hazard_pipe_tracker.sv
// Producer side of the hazard interface: tracks register IDs and control
// bits of the instructions in EX, MEM and WB, one cycle per stage.
// Ports: clock, reset (async active-high); ID_* decoded fields in; stall
// vector ID/EX/MEM_Stall and ID_Flush in; EX_*, MEM_*, WB_* stage fields out;
// Stall_Count (cycles with ID_Stall) and Bubble_Count (bubbles into EX) out.
module hazard_pipe_tracker
  import hazard_pipe_tracker_pkg::*;
(
  input  logic                clock,
  input  logic                reset,

  input  logic                ID_Valid,
  input  logic [REG_ID_W-1:0] ID_Rs,
  input  logic [REG_ID_W-1:0] ID_Rt,
  input  logic [REG_ID_W-1:0] ID_Rd,
  input  logic                ID_RegW,
  input  logic                ID_MemR,
  input  logic                ID_Wants_Rs,
  input  logic                ID_Needs_Rs,
  input  logic                ID_Wants_Rt,
  input  logic                ID_Needs_Rt,

  input  logic                ID_Stall,
  input  logic                EX_Stall,
  input  logic                MEM_Stall,
  input  logic                ID_Flush,

  output logic [REG_ID_W-1:0] EX_Rs,
  output logic [REG_ID_W-1:0] EX_Rt,
  output logic [REG_ID_W-1:0] EX_Rd,
  output logic                EX_RegW,
  output logic                EX_MemR,
  output logic                EX_Wants_Rs,
  output logic                EX_Needs_Rs,
  output logic                EX_Wants_Rt,
  output logic                EX_Needs_Rt,

  output logic [REG_ID_W-1:0] MEM_Rd,
  output logic                MEM_RegW,
  output logic                MEM_MemR,
  output logic [REG_ID_W-1:0] WB_Rd,
  output logic                WB_RegW,
  output logic                WB_MemR,

  output logic                EX_Valid,
  output logic                MEM_Valid,
  output logic                WB_Valid,

  output logic [CNT_W-1:0]    Stall_Count,
  output logic [CNT_W-1:0]    Bubble_Count
);

  ex_stage_t  id_fields;
  ex_stage_t  ex_q;
  mem_stage_t ex_to_mem;
  mem_stage_t mem_q;
  mem_stage_t wb_q;

  logic ex_bubble;
  logic bubble_inserted;

  cnt_t stall_cnt_q;
  cnt_t stall_cnt_d;
  cnt_t bubble_cnt_q;
  cnt_t bubble_cnt_d;

  // ---------------------------------------------------------------------
  // ID -> EX
  // ---------------------------------------------------------------------
  always_comb begin
    id_fields          = EX_BUBBLE;
    id_fields.valid    = 1'b1;
    id_fields.rs       = ID_Rs;
    id_fields.rt       = ID_Rt;
    id_fields.rd       = ID_Rd;
    id_fields.reg_w    = ID_RegW;
    id_fields.mem_r    = ID_MemR;
    id_fields.wants_rs = ID_Wants_Rs;
    id_fields.needs_rs = ID_Needs_Rs;
    id_fields.wants_rt = ID_Wants_Rt;
    id_fields.needs_rt = ID_Needs_Rt;
  end

  // A flush alone is enough to bubble EX, so flush+stall together yields a
  // single bubble rather than a held instruction.
  assign ex_bubble = ID_Stall | ID_Flush | ~ID_Valid;

  pipe_stage_reg #(
    .W      (EX_STAGE_W),
    .BUBBLE (EX_BUBBLE)
  ) u_ex_stage (
    .clk_i    (clock),
    .rst_i    (reset),
    .hold_i   (EX_Stall),
    .bubble_i (ex_bubble),
    .load_i   (1'b1),
    .d_i      (id_fields),
    .q_o      (ex_q)
  );

  // ---------------------------------------------------------------------
  // EX -> MEM
  // ---------------------------------------------------------------------
  // Forward the valid-qualified write flags so MEM never inherits a write
  // from a bubble even if stale bits were ever present in EX.
  always_comb begin
    ex_to_mem       = MEM_BUBBLE;
    ex_to_mem.valid = ex_q.valid;
    ex_to_mem.rd    = ex_q.rd;
    ex_to_mem.reg_w = ex_q.reg_w & ex_q.valid;
    ex_to_mem.mem_r = ex_q.mem_r & ex_q.valid;
  end

  // A stalled EX keeps its instruction, so MEM must take a bubble to avoid
  // duplicating it downstream.
  pipe_stage_reg #(
    .W      (MEM_STAGE_W),
    .BUBBLE (MEM_BUBBLE)
  ) u_mem_stage (
    .clk_i    (clock),
    .rst_i    (reset),
    .hold_i   (MEM_Stall),
    .bubble_i (EX_Stall),
    .load_i   (1'b1),
    .d_i      (ex_to_mem),
    .q_o      (mem_q)
  );

  // ---------------------------------------------------------------------
  // MEM -> WB (never stalls)
  // ---------------------------------------------------------------------
  pipe_stage_reg #(
    .W      (MEM_STAGE_W),
    .BUBBLE (MEM_BUBBLE)
  ) u_wb_stage (
    .clk_i    (clock),
    .rst_i    (reset),
    .hold_i   (1'b0),
    .bubble_i (1'b0),
    .load_i   (1'b1),
    .d_i      (mem_q),
    .q_o      (wb_q)
  );

  // ---------------------------------------------------------------------
  // Event counters
  // ---------------------------------------------------------------------
  // Only a real instruction turned into a bubble counts; an empty ID slot
  // or a held EX does not insert anything.
  assign bubble_inserted = ~EX_Stall & ID_Valid & (ID_Stall | ID_Flush);

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (ID_Stall) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end
    if (bubble_inserted) begin
      bubble_cnt_d = sat_inc(bubble_cnt_q);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  // Rd of zero is passed through untouched; filtering $zero is left to the
  // hazard checker.
  assign EX_Valid     = ex_q.valid;
  assign EX_Rs        = ex_q.rs;
  assign EX_Rt        = ex_q.rt;
  assign EX_Rd        = ex_q.rd;
  assign EX_RegW      = ex_q.reg_w & ex_q.valid;
  assign EX_MemR      = ex_q.mem_r & ex_q.valid;
  assign EX_Wants_Rs  = ex_q.wants_rs;
  assign EX_Needs_Rs  = ex_q.needs_rs;
  assign EX_Wants_Rt  = ex_q.wants_rt;
  assign EX_Needs_Rt  = ex_q.needs_rt;

  assign MEM_Valid    = mem_q.valid;
  assign MEM_Rd       = mem_q.rd;
  assign MEM_RegW     = mem_q.reg_w & mem_q.valid;
  assign MEM_MemR     = mem_q.mem_r & mem_q.valid;

  assign WB_Valid     = wb_q.valid;
  assign WB_Rd        = wb_q.rd;
  assign WB_RegW      = wb_q.reg_w & wb_q.valid;
  assign WB_MemR      = wb_q.mem_r & wb_q.valid;

  assign Stall_Count  = stall_cnt_q;
  assign Bubble_Count = bubble_cnt_q;

endmodule

// File: tb/tb_hazard_pipe_tracker.sv
module tb_hazard_pipe_tracker;

  logic       clock;
  logic       reset;
  logic       ID_Valid;
  logic [4:0] ID_Rs, ID_Rt, ID_Rd;
  logic       ID_RegW, ID_MemR;
  logic       ID_Wants_Rs, ID_Needs_Rs, ID_Wants_Rt, ID_Needs_Rt;
  logic       ID_Stall, EX_Stall, MEM_Stall, ID_Flush;

  logic [4:0]  EX_Rs, EX_Rt, EX_Rd;
  logic        EX_RegW, EX_MemR, EX_Wants_Rs, EX_Needs_Rs, EX_Wants_Rt, EX_Needs_Rt;
  logic [4:0]  MEM_Rd, WB_Rd;
  logic        MEM_RegW, MEM_MemR, WB_RegW, WB_MemR;
  logic        EX_Valid, MEM_Valid, WB_Valid;
  logic [15:0] Stall_Count, Bubble_Count;

  int n_assert = 0;
  int n_fail   = 0;

  hazard_pipe_tracker dut (
    .clock(clock), .reset(reset),
    .ID_Valid(ID_Valid), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
    .ID_RegW(ID_RegW), .ID_MemR(ID_MemR),
    .ID_Wants_Rs(ID_Wants_Rs), .ID_Needs_Rs(ID_Needs_Rs),
    .ID_Wants_Rt(ID_Wants_Rt), .ID_Needs_Rt(ID_Needs_Rt),
    .ID_Stall(ID_Stall), .EX_Stall(EX_Stall), .MEM_Stall(MEM_Stall), .ID_Flush(ID_Flush),
    .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd), .EX_RegW(EX_RegW), .EX_MemR(EX_MemR),
    .EX_Wants_Rs(EX_Wants_Rs), .EX_Needs_Rs(EX_Needs_Rs),
    .EX_Wants_Rt(EX_Wants_Rt), .EX_Needs_Rt(EX_Needs_Rt),
    .MEM_Rd(MEM_Rd), .MEM_RegW(MEM_RegW), .MEM_MemR(MEM_MemR),
    .WB_Rd(WB_Rd), .WB_RegW(WB_RegW), .WB_MemR(WB_MemR),
    .EX_Valid(EX_Valid), .MEM_Valid(MEM_Valid), .WB_Valid(WB_Valid),
    .Stall_Count(Stall_Count), .Bubble_Count(Bubble_Count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: an array of stage records indexed EX=0, MEM=1, WB=2.
  // Each record: valid, rs, rt, rd, regw, memr, wrs, nrs, wrt, nrt.
  int m_v   [3];
  int m_rs  [3];
  int m_rt  [3];
  int m_rd  [3];
  int m_rw  [3];
  int m_mr  [3];
  int m_wrs [3];
  int m_nrs [3];
  int m_wrt [3];
  int m_nrt [3];
  int m_stalls;
  int m_bubbles;

  task automatic model_clear_stage(input int s);
    m_v[s] = 0; m_rs[s] = 0; m_rt[s] = 0; m_rd[s] = 0; m_rw[s] = 0;
    m_mr[s] = 0; m_wrs[s] = 0; m_nrs[s] = 0; m_wrt[s] = 0; m_nrt[s] = 0;
  endtask

  task automatic model_reset();
    for (int s = 0; s < 3; s++) model_clear_stage(s);
    m_stalls  = 0;
    m_bubbles = 0;
  endtask

  // One clock of the pipeline as described by the stage rules.
  task automatic model_step();
    // WB always takes whatever MEM held.
    m_v[2] = m_v[1]; m_rd[2] = m_rd[1]; m_rw[2] = m_rw[1]; m_mr[2] = m_mr[1];
    // MEM: hold / bubble behind a stalled EX / advance.
    if (MEM_Stall) begin
    end else if (EX_Stall) begin
      model_clear_stage(1);
    end else begin
      m_v[1] = m_v[0]; m_rd[1] = m_rd[0];
      m_rw[1] = m_rw[0] & m_v[0]; m_mr[1] = m_mr[0] & m_v[0];
    end
    // Counters use the inputs of this cycle.
    if (ID_Stall && m_stalls < 65535) m_stalls++;
    if (!EX_Stall && ID_Valid && (ID_Stall || ID_Flush) && m_bubbles < 65535) m_bubbles++;
    // EX: hold / bubble / load from ID.
    if (EX_Stall) begin
    end else if (ID_Stall || ID_Flush || !ID_Valid) begin
      model_clear_stage(0);
    end else begin
      m_v[0] = 1; m_rs[0] = ID_Rs; m_rt[0] = ID_Rt; m_rd[0] = ID_Rd;
      m_rw[0] = ID_RegW; m_mr[0] = ID_MemR;
      m_wrs[0] = ID_Wants_Rs; m_nrs[0] = ID_Needs_Rs;
      m_wrt[0] = ID_Wants_Rt; m_nrt[0] = ID_Needs_Rt;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("EX_Valid", EX_Valid, m_v[0]);
    chk("EX_Rs", EX_Rs, m_rs[0]);
    chk("EX_Rt", EX_Rt, m_rt[0]);
    chk("EX_Rd", EX_Rd, m_rd[0]);
    chk("EX_RegW", EX_RegW, m_rw[0] & m_v[0]);
    chk("EX_MemR", EX_MemR, m_mr[0] & m_v[0]);
    chk("EX_Wants_Rs", EX_Wants_Rs, m_wrs[0]);
    chk("EX_Needs_Rs", EX_Needs_Rs, m_nrs[0]);
    chk("EX_Wants_Rt", EX_Wants_Rt, m_wrt[0]);
    chk("EX_Needs_Rt", EX_Needs_Rt, m_nrt[0]);
    chk("MEM_Valid", MEM_Valid, m_v[1]);
    chk("MEM_Rd", MEM_Rd, m_rd[1]);
    chk("MEM_RegW", MEM_RegW, m_rw[1] & m_v[1]);
    chk("MEM_MemR", MEM_MemR, m_mr[1] & m_v[1]);
    chk("WB_Valid", WB_Valid, m_v[2]);
    chk("WB_Rd", WB_Rd, m_rd[2]);
    chk("WB_RegW", WB_RegW, m_rw[2] & m_v[2]);
    chk("WB_MemR", WB_MemR, m_mr[2] & m_v[2]);
    chk("Stall_Count", Stall_Count, m_stalls);
    chk("Bubble_Count", Bubble_Count, m_bubbles);
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled there too.
  task automatic tick(input bit do_check);
    @(posedge clock);
    model_step();
    #1;
    if (do_check) check_all();
  endtask

  task automatic idle_inputs();
    ID_Valid = 0; ID_Rs = 0; ID_Rt = 0; ID_Rd = 0; ID_RegW = 0; ID_MemR = 0;
    ID_Wants_Rs = 0; ID_Needs_Rs = 0; ID_Wants_Rt = 0; ID_Needs_Rt = 0;
    ID_Stall = 0; EX_Stall = 0; MEM_Stall = 0; ID_Flush = 0;
  endtask

  task automatic set_instr(input int rs, input int rt, input int rd, input bit rw, input bit mr);
    ID_Valid = 1; ID_Rs = 5'(rs); ID_Rt = 5'(rt); ID_Rd = 5'(rd);
    ID_RegW = rw; ID_MemR = mr;
    ID_Wants_Rs = 1; ID_Needs_Rs = 1; ID_Wants_Rt = 1; ID_Needs_Rt = 0;
  endtask

  // Pulse reset between edges and check the whole pipe reads as bubbles
  // while reset is still held.
  task automatic do_reset();
    reset = 1;
    #2;
    model_reset();
    check_all();
    #3;
    reset = 0;
  endtask

  initial begin
    reset = 0;
    idle_inputs();
    #1;
    do_reset();

    // Basic flow: one instruction walks EX -> MEM -> WB.
    set_instr(1, 2, 5, 1, 0);
    tick(1);
    chk("flow_ex_rd", EX_Rd, 5);
    idle_inputs();
    tick(1);
    chk("flow_mem_rd", MEM_Rd, 5);
    tick(1);
    chk("flow_wb_rd", WB_Rd, 5);
    chk("flow_wb_regw", WB_RegW, 1);

    // ID stall for two cycles with a valid instruction.
    do_reset();
    set_instr(3, 4, 9, 1, 1);
    ID_Stall = 1;
    tick(1);
    chk("stall_ex_valid1", EX_Valid, 0);
    tick(1);
    chk("stall_ex_valid2", EX_Valid, 0);
    chk("stall_count2", Stall_Count, 2);
    chk("stall_bubbles2", Bubble_Count, 2);
    idle_inputs();
    tick(1);

    // EX stall holds Rd=7 and sends a bubble to MEM.
    set_instr(6, 8, 7, 1, 0);
    tick(1);
    set_instr(10, 11, 3, 1, 1);
    EX_Stall = 1;
    tick(1);
    chk("exstall_rd_held", EX_Rd, 7);
    chk("exstall_mem_valid", MEM_Valid, 0);
    chk("exstall_mem_regw", MEM_RegW, 0);
    idle_inputs();
    tick(1);

    // Flush and stall together: one bubble, counted once.
    do_reset();
    set_instr(12, 13, 14, 1, 0);
    ID_Flush = 1;
    ID_Stall = 1;
    tick(1);
    chk("flush_ex_valid", EX_Valid, 0);
    chk("flush_bubbles", Bubble_Count, 1);
    idle_inputs();

    // Rd of zero passes through untouched.
    set_instr(0, 0, 0, 1, 0);
    tick(1);
    chk("rd0_ex_regw", EX_RegW, 1);
    idle_inputs();
    tick(1);
    tick(1);
    chk("rd0_wb_regw", WB_RegW, 1);

    // Stall counter saturation.
    do_reset();
    ID_Stall = 1;
    for (int i = 0; i < 65534; i++) tick(0);
    check_all();
    chk("sat_fffe", Stall_Count, 16'hFFFE);
    for (int i = 0; i < 3; i++) tick(1);
    chk("sat_ffff", Stall_Count, 16'hFFFF);
    idle_inputs();

    // Mid-operation reset with every stage valid and counters non-zero.
    do_reset();
    ID_Stall = 1;
    tick(1);
    ID_Stall = 0;
    for (int i = 0; i < 3; i++) begin
      set_instr(i + 1, i + 2, i + 20, 1, 1);
      tick(1);
    end
    chk("pre_rst_wb_valid", WB_Valid, 1);
    reset = 1;
    #1;
    chk("rst_ex_valid", EX_Valid, 0);
    chk("rst_mem_valid", MEM_Valid, 0);
    chk("rst_wb_valid", WB_Valid, 0);
    chk("rst_ex_regw", EX_RegW, 0);
    chk("rst_mem_memr", MEM_MemR, 0);
    chk("rst_wb_regw", WB_RegW, 0);
    chk("rst_stall_cnt", Stall_Count, 0);
    chk("rst_bubble_cnt", Bubble_Count, 0);
    model_reset();
    check_all();
    #3;
    reset = 0;
    set_instr(4, 5, 6, 1, 0);
    tick(1);
    chk("post_rst_ex_valid", EX_Valid, 1);

    // Randomized traffic against the model, with one reset in the middle.
    for (int i = 0; i < 400; i++) begin
      ID_Valid    = ($urandom_range(0, 3) != 0);
      ID_Rs       = 5'($urandom_range(0, 31));
      ID_Rt       = 5'($urandom_range(0, 31));
      ID_Rd       = 5'($urandom_range(0, 31));
      ID_RegW     = 1'($urandom_range(0, 1));
      ID_MemR     = 1'($urandom_range(0, 1));
      ID_Wants_Rs = 1'($urandom_range(0, 1));
      ID_Needs_Rs = 1'($urandom_range(0, 1));
      ID_Wants_Rt = 1'($urandom_range(0, 1));
      ID_Needs_Rt = 1'($urandom_range(0, 1));
      ID_Stall    = ($urandom_range(0, 4) == 0);
      EX_Stall    = ($urandom_range(0, 6) == 0);
      MEM_Stall   = ($urandom_range(0, 8) == 0);
      ID_Flush    = ($urandom_range(0, 7) == 0);
      if (i == 200) do_reset();
      tick(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
